mul_div_unit: RTL and testbench



---
 rtl/mul_div_unit_pkg.sv | 32 +++
 rtl/mul_div_unit_if.sv | 22 ++
 rtl/mul_div_unit_md_counter.sv | 30 +++
 rtl/mul_div_unit.sv | 116 +++++++++++
 tb/tb_mul_div_unit.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: operation encodings,
// default latencies and the start-class predicate also used by the Decode stall logic.
package mul_div_unit_pkg;

    localparam logic [3:0] SEL_NONE  = 4'd0;
    localparam logic [3:0] SEL_MULT  = 4'd1;
    localparam logic [3:0] SEL_MULTU = 4'd2;
    localparam logic [3:0] SEL_DIV   = 4'd3;
    localparam logic [3:0] SEL_DIVU  = 4'd4;
    localparam logic [3:0] SEL_MTHI  = 4'd5;
    localparam logic [3:0] SEL_MTLO  = 4'd6;
    localparam logic [3:0] SEL_MADD  = 4'd7;
    localparam logic [3:0] SEL_MSUB  = 4'd8;
    localparam logic [3:0] SEL_MFHI  = 4'd9;
    localparam logic [3:0] SEL_MFLO  = 4'd10;

    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;

    // Busy counter width; latencies up to 255 cycles.
    localparam int CNT_W = 8;

    function automatic logic is_start_class(input logic [3:0] sel);
        return (sel == SEL_MULT) || (sel == SEL_MULTU) || (sel == SEL_DIV) ||
               (sel == SEL_DIVU) || (sel == SEL_MADD)  || (sel == SEL_MSUB);
    endfunction

    function automatic logic is_div(input logic [3:0] sel);
        return (sel == SEL_DIV) || (sel == SEL_DIVU);
    endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Execute-stage bundle between the pipeline and the multiply/divide unit.
interface mul_div_unit_if;

    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  sel;
    logic        start;
    logic        commit;
    logic        busy;
    logic [31:0] out;

    modport master (
        output A, B, sel, start, commit,
        input  busy, out
    );

    modport slave (
        input  A, B, sel, start, commit,
        output busy, out
    );

endinterface

// File: rtl/mul_div_unit_md_counter.sv
// Down-counting busy timer: loads a latency, counts to zero, flags the 1->0 edge.
module md_counter
    import mul_div_unit_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero,
    output logic         last
);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);
    assign last = (count == W'(1));

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO. The result is computed at accept
// time and held in pending registers until the busy counter retires it.
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic           clk,
    input  logic           reset,
    mul_div_unit_if.slave  bus
);

    logic [31:0] hi, lo;
    logic [31:0] pend_hi, pend_lo;
    logic        pend_wr;

    logic        start_req, accept, cnt_zero, cnt_last;
    logic [CNT_W-1:0] load_val;

    logic signed [63:0] a_s64, b_s64;
    logic [63:0]        a_u64, b_u64;
    logic [63:0]        prod_s, prod_u, hilo;
    logic signed [31:0] a_s, b_s, quot_s, rem_s;
    logic [31:0]        quot_u, rem_u;

    logic [31:0] nxt_hi, nxt_lo;
    logic        nxt_wr;

    assign start_req = bus.start & bus.commit & is_start_class(bus.sel);
    assign accept    = start_req & cnt_zero;
    assign bus.busy  = start_req | ~cnt_zero;

    assign load_val = is_div(bus.sel) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);

    md_counter #(.W(CNT_W)) u_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (accept),
        .load_val (load_val),
        .zero     (cnt_zero),
        .last     (cnt_last)
    );

    assign a_s64  = {{32{bus.A[31]}}, bus.A};
    assign b_s64  = {{32{bus.B[31]}}, bus.B};
    assign a_u64  = {32'd0, bus.A};
    assign b_u64  = {32'd0, bus.B};
    assign prod_s = a_s64 * b_s64;
    assign prod_u = a_u64 * b_u64;
    assign hilo   = {hi, lo};

    // Verilog signed divide already truncates toward zero with dividend-signed remainder.
    assign a_s    = bus.A;
    assign b_s    = bus.B;
    assign quot_s = a_s / b_s;
    assign rem_s  = a_s % b_s;
    assign quot_u = bus.A / bus.B;
    assign rem_u  = bus.A % bus.B;

    always_comb begin
        nxt_hi = hi;
        nxt_lo = lo;
        nxt_wr = 1'b1;
        case (bus.sel)
            SEL_MULT:  {nxt_hi, nxt_lo} = prod_s;
            SEL_MULTU: {nxt_hi, nxt_lo} = prod_u;
            SEL_MADD:  {nxt_hi, nxt_lo} = hilo + prod_s;
            SEL_MSUB:  {nxt_hi, nxt_lo} = hilo - prod_s;
            SEL_DIV: begin
                nxt_hi = rem_s;
                nxt_lo = quot_s;
                nxt_wr = (bus.B != 32'd0);
            end
            SEL_DIVU: begin
                nxt_hi = rem_u;
                nxt_lo = quot_u;
                nxt_wr = (bus.B != 32'd0);
            end
            default: nxt_wr = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_hi <= '0;
            pend_lo <= '0;
            pend_wr <= 1'b0;
        end else if (accept) begin
            pend_hi <= nxt_hi;
            pend_lo <= nxt_lo;
            pend_wr <= nxt_wr;
        end
    end

    // mthi/mtlo need an idle counter, so they can never collide with a retire.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end else if (cnt_last && pend_wr) begin
            hi <= pend_hi;
            lo <= pend_lo;
        end else if (bus.commit && cnt_zero) begin
            if (bus.sel == SEL_MTHI) hi <= bus.A;
            if (bus.sel == SEL_MTLO) lo <= bus.A;
        end
    end

    always_comb begin
        bus.out = 32'd0;
        if (bus.sel == SEL_MFHI) bus.out = hi;
        else if (bus.sel == SEL_MFLO) bus.out = lo;
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed checks of the multiply/divide unit: latency, results, HI/LO moves,
// commit gating, reset during an operation and divide by zero.
module tb_mul_div_unit;
    import mul_div_unit_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    mul_div_unit_if bus ();

    mul_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.sel    = SEL_NONE;
        bus.start  = 1'b0;
        bus.commit = 1'b1;
    endtask

    task automatic read_chk(input logic [3:0] s, input logic [31:0] exp, input string tag);
        bus.sel = s;
        #1;
        check(tag, bus.out, exp);
        bus.sel = SEL_NONE;
    endtask

    // Issues a start-class op, scrambles operands after accept, counts busy cycles.
    task automatic do_op(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b,
                         input int exp_cycles, input string tag);
        int n;
        n = 0;
        @(posedge clk); #1;
        bus.sel = s; bus.A = a; bus.B = b; bus.start = 1'b1; bus.commit = 1'b1;
        #3;
        while (bus.busy && n < 50) begin
            n++;
            @(posedge clk); #1;
            bus.start = 1'b0; bus.sel = SEL_NONE;
            bus.A = $urandom; bus.B = $urandom;
            #3;
        end
        check(tag, n, exp_cycles);
    endtask

    task automatic write_hl(input logic [3:0] s, input logic [31:0] a, input logic c);
        @(posedge clk); #1;
        bus.sel = s; bus.A = a; bus.start = 1'b0; bus.commit = c;
        @(posedge clk); #1;
        idle_inputs();
    endtask

    initial begin
        int n;
        reset = 1'b1;
        bus.A = '0; bus.B = '0;
        idle_inputs();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset_busy", bus.busy, 0);
        read_chk(SEL_MFHI, 32'h0, "reset_hi");
        read_chk(SEL_MFLO, 32'h0, "reset_lo");

        do_op(SEL_MULT, 32'hFFFF_FFFF, 32'd2, 6, "mult_busy");
        read_chk(SEL_MFHI, 32'hFFFF_FFFF, "mult_hi");
        read_chk(SEL_MFLO, 32'hFFFF_FFFE, "mult_lo");
        read_chk(SEL_NONE, 32'h0, "out_none");

        do_op(SEL_MULTU, 32'hFFFF_FFFF, 32'd2, 6, "multu_busy");
        read_chk(SEL_MFHI, 32'h1, "multu_hi");
        read_chk(SEL_MFLO, 32'hFFFF_FFFE, "multu_lo");

        do_op(SEL_DIV, 32'hFFFF_FFF9, 32'd2, 11, "div_busy");
        read_chk(SEL_MFHI, 32'hFFFF_FFFF, "div_hi");
        read_chk(SEL_MFLO, 32'hFFFF_FFFD, "div_lo");

        do_op(SEL_DIVU, 32'd7, 32'd2, 11, "divu_busy");
        read_chk(SEL_MFHI, 32'd1, "divu_hi");
        read_chk(SEL_MFLO, 32'd3, "divu_lo");

        do_op(SEL_MULT, 32'd3, 32'd4, 6, "mult34_busy");
        read_chk(SEL_MFLO, 32'd12, "mult34_lo");
        do_op(SEL_MADD, 32'hFFFF_FFFE, 32'd5, 6, "madd_busy");
        read_chk(SEL_MFHI, 32'h0, "madd_hi");
        read_chk(SEL_MFLO, 32'd2, "madd_lo");
        do_op(SEL_MSUB, 32'd1, 32'd3, 6, "msub_busy");
        read_chk(SEL_MFHI, 32'hFFFF_FFFF, "msub_hi");
        read_chk(SEL_MFLO, 32'hFFFF_FFFF, "msub_lo");

        write_hl(SEL_MTHI, 32'h1234, 1'b1);
        read_chk(SEL_MFHI, 32'h1234, "mthi");
        write_hl(SEL_MTLO, 32'hDEAD_BEEF, 1'b0);
        read_chk(SEL_MFLO, 32'hFFFF_FFFF, "mtlo_nocommit");

        // start with commit low must never raise busy
        @(posedge clk); #1;
        bus.sel = SEL_MULT; bus.A = 32'd9; bus.B = 32'd9; bus.start = 1'b1; bus.commit = 1'b0;
        #3;
        check("nocommit_busy0", bus.busy, 0);
        n = 0;
        repeat (8) begin
            @(posedge clk); #1;
            idle_inputs();
            #3;
            if (bus.busy) n++;
        end
        check("nocommit_never_busy", n, 0);
        read_chk(SEL_MFHI, 32'h1234, "nocommit_hi");
        read_chk(SEL_MFLO, 32'hFFFF_FFFF, "nocommit_lo");

        // reset two cycles into a divide
        @(posedge clk); #1;
        bus.sel = SEL_DIV; bus.A = 32'd100; bus.B = 32'd7; bus.start = 1'b1; bus.commit = 1'b1;
        @(posedge clk); #1;
        idle_inputs();
        @(posedge clk); #3;
        check("div_inflight_busy", bus.busy, 1);
        reset = 1'b1;
        #1;
        check("reset_mid_busy", bus.busy, 0);
        read_chk(SEL_MFHI, 32'h0, "reset_mid_hi");
        read_chk(SEL_MFLO, 32'h0, "reset_mid_lo");
        @(negedge clk);
        reset = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        check("reset_mid_busy_later", bus.busy, 0);
        read_chk(SEL_MFHI, 32'h0, "reset_mid_hi_later");
        read_chk(SEL_MFLO, 32'h0, "reset_mid_lo_later");

        write_hl(SEL_MTHI, 32'd5, 1'b1);
        write_hl(SEL_MTLO, 32'd6, 1'b1);
        do_op(SEL_DIV, 32'd40, 32'd0, 11, "div0_busy");
        read_chk(SEL_MFHI, 32'd5, "div0_hi");
        read_chk(SEL_MFLO, 32'd6, "div0_lo");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
